fetch_redirect_unit: RTL

//  Front-end PC generator and branch-resolution stage paired with the 8-entry BTB predictor.
//  - Owns the PC register and indexes the predictor every cycle.
//  - Carries prediction metadata through IF/ID and ID/EX.
//  - Detects mispredicts in EX, redirects fetch and flushes wrong-path stages.
//  - Drives the predictor's update port: br, br_taken, index_update, br_target_I.

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_meta_reg.sv | 35 +++
 rtl/fetch_redirect_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - CPU word type and branch-prediction metadata shared by the fetch front end
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

package bp_pkg;
    import cpu_types_pkg::*;

    localparam int BP_IDX_W = 3;

    typedef struct packed {
        logic                valid;
        word_t               pc;
        logic                pred_taken;
        word_t               pred_target;
        logic [BP_IDX_W-1:0] index;
    } bp_meta_t;
endpackage

// File: rtl/bp_meta_reg.sv
// rtl/bp_meta_reg.sv - one prediction-metadata pipeline register (IF/ID or ID/EX)
module bp_meta_reg
    import cpu_types_pkg::*;
    import bp_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     en_i,
    input  logic     flush_i,
    input  bp_meta_t d_i,
    output bp_meta_t q_o
);

    bp_meta_t meta_q;
    bp_meta_t meta_d;

    // A flushed slot is cleared entirely so stale fields never leak downstream.
    always_comb begin
        meta_d = meta_q;
        if (en_i) begin
            meta_d = flush_i ? '0 : d_i;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            meta_q <= '0;
        end else begin
            meta_q <= meta_d;
        end
    end

    assign q_o = meta_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC generator, mispredict detection and predictor update for the BTB front end
module fetch_redirect_unit
    import cpu_types_pkg::*;
    import bp_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    IDX_W    = BP_IDX_W,
    parameter int    CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             pc_en,
    output word_t            pc,
    output logic [IDX_W-1:0] index_I,
    input  logic             predict,
    input  word_t            br_target_O,
    input  logic             id_jump,
    input  word_t            id_jump_target,
    input  logic             ex_branch,
    input  logic             ex_taken,
    input  word_t            ex_target,
    output logic             br,
    output logic             br_taken,
    output logic [IDX_W-1:0] index_update,
    output word_t            br_target_I,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    word_t            pc_q;
    word_t            pc_d;
    bp_meta_t         if_cap;
    bp_meta_t         ifid_q;
    bp_meta_t         idex_q;
    logic             ex_v;
    logic             mispredict;
    logic             jump_take;
    word_t            fix_pc;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q;
    logic [CNT_W-1:0] mis_cnt_d;

    assign index_I = pc_q[IDX_W+1:2];

    always_comb begin
        if_cap             = '0;
        if_cap.valid       = 1'b1;
        if_cap.pc          = pc_q;
        if_cap.pred_taken  = predict;
        if_cap.pred_target = br_target_O;
        if_cap.index       = index_I;
    end

    // A predicted-taken non-branch (index aliasing) is also a mispredict.
    always_comb begin
        ex_v       = idex_q.valid;
        mispredict = ex_v & ((ex_branch & (idex_q.pred_taken != ex_taken))
                           | (ex_branch & ex_taken & (idex_q.pred_target != ex_target))
                           | (!ex_branch & idex_q.pred_taken));
        fix_pc     = (ex_branch & ex_taken) ? ex_target : idex_q.pc + 32'd4;
        jump_take  = id_jump & ifid_q.valid;
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            if (mispredict) begin
                pc_d = fix_pc;
            end else if (jump_take) begin
                pc_d = id_jump_target;
            end else if (predict) begin
                pc_d = br_target_O;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    assign flush_ifid = pc_en & (mispredict | jump_take);
    assign flush_idex = pc_en & mispredict;

    bp_meta_reg u_ifid (
        .CLK     (CLK),
        .nRST    (nRST),
        .en_i    (pc_en),
        .flush_i (flush_ifid),
        .d_i     (if_cap),
        .q_o     (ifid_q)
    );

    bp_meta_reg u_idex (
        .CLK     (CLK),
        .nRST    (nRST),
        .en_i    (pc_en),
        .flush_i (flush_idex),
        .d_i     (ifid_q),
        .q_o     (idex_q)
    );

    assign br           = ex_v & ex_branch;
    assign br_taken     = ex_taken;
    assign index_update = idex_q.index;
    assign br_target_I  = ex_target;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (pc_en && br && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + 1'b1;
        end
        if (pc_en && mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q      <= RESET_PC;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            pc_q      <= pc_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign pc            = pc_q;
    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;

endmodule
